// File: rtl/instruction_fetch_stage.sv
// ---------------------------------------------------------------------------
// instruction_fetch_stage
//
// Front-end fetch stage. Generates the fetch PC, issues pipelined requests to
// the instruction cache, buffers in-order cache responses in a small FIFO and
// presents one {PC, instruction} pair per cycle to the decoding stage through
// an output pipeline register. Handles stall, clear (bubble) and taken-branch
// redirect, including dropping stale in-flight cache responses.
//
// Ports:
//   CLK                 in   1   clock, all state updates on rising edge
//   RST                 in   1   synchronous active-high reset
//   STALL_FETCH_STAGE   in   1   hold output register, no FIFO pop
//   CLEAR_FETCH_STAGE   in   1   load bubble into output register
//   BRANCH_TAKEN        in   1   redirect fetch to BRANCH_TARGET, flush
//   BRANCH_TARGET       in   32  redirect address
//   ICACHE_REQUEST      out  1   fetch request valid
//   ICACHE_ADDRESS      out  32  fetch address, word aligned
//   ICACHE_READY        in   1   cache accepts request this cycle
//   ICACHE_VALID        in   1   response valid, in request order
//   ICACHE_INSTRUCTION  in   32  response data
//   PC_OUT              out  32  registered PC to decoding stage
//   INSTRUCTION         out  32  registered instruction to decoding stage
//   INSTRUCTION_VALID   out  1   1 = real instruction, 0 = bubble
//
// Handshake: a request transfers on a rising edge where ICACHE_REQUEST and
// ICACHE_READY are both 1; REQUEST never depends on READY. Responses have no
// ready: the credit rule (in-flight + buffered < FIFO_DEPTH) guarantees a free
// FIFO slot for every response, so ICACHE_VALID is always accepted.
// ---------------------------------------------------------------------------
module instruction_fetch_stage #(
  parameter logic [31:0] PC_RESET   = 32'h0000_0000,
  parameter logic [31:0] NOP        = 32'h0000_0013,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        STALL_FETCH_STAGE,
  input  logic        CLEAR_FETCH_STAGE,
  input  logic        BRANCH_TAKEN,
  input  logic [31:0] BRANCH_TARGET,
  output logic        ICACHE_REQUEST,
  output logic [31:0] ICACHE_ADDRESS,
  input  logic        ICACHE_READY,
  input  logic        ICACHE_VALID,
  input  logic [31:0] ICACHE_INSTRUCTION,
  output logic [31:0] PC_OUT,
  output logic [31:0] INSTRUCTION,
  output logic        INSTRUCTION_VALID
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] ONE   = CW'(1);
  localparam logic [CW:0]   LIMIT = (CW + 1)'(FIFO_DEPTH);

  // Fetch-side state
  logic [31:0]   fetch_pc;
  logic [31:0]   resp_pc;      // PC of the next non-stale response
  logic [CW-1:0] outstanding;  // all in-flight requests, stale ones included
  logic [CW-1:0] discard;      // subset of outstanding that must be dropped

  // Response FIFO
  logic [31:0]   fifo_pc   [FIFO_DEPTH];
  logic [31:0]   fifo_data [FIFO_DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [CW-1:0] count;

  logic [31:0] branch_pc;
  logic        credit_ok;
  logic        handshake;
  logic        push;
  logic        pop;
  logic [CW-1:0] outstanding_dec;
  logic [CW-1:0] outstanding_next;

  assign branch_pc = {BRANCH_TARGET[31:2], 2'b00};
  assign credit_ok = ({1'b0, outstanding} + {1'b0, count}) < LIMIT;

  assign ICACHE_REQUEST = !RST && !BRANCH_TAKEN && credit_ok;
  assign ICACHE_ADDRESS = fetch_pc;

  assign handshake = ICACHE_REQUEST && ICACHE_READY;
  assign push      = ICACHE_VALID && !BRANCH_TAKEN && (discard == '0);
  assign pop       = !BRANCH_TAKEN && !CLEAR_FETCH_STAGE && !STALL_FETCH_STAGE &&
                     (count != '0);

  always_comb begin
    outstanding_dec  = outstanding;
    outstanding_next = outstanding;
    // Guard against a response with nothing in flight so the counter
    // cannot wrap.
    if (ICACHE_VALID && (outstanding != '0)) begin
      outstanding_dec = outstanding - ONE;
    end
    outstanding_next = outstanding_dec;
    if (handshake) begin
      outstanding_next = outstanding_dec + ONE;
    end
  end

  // Fetch PC, in-flight accounting and response PC tracker
  always_ff @(posedge CLK) begin
    if (RST) begin
      fetch_pc    <= PC_RESET;
      resp_pc     <= PC_RESET;
      outstanding <= '0;
      discard     <= '0;
    end else begin
      outstanding <= outstanding_next;
      if (BRANCH_TAKEN) begin
        fetch_pc <= branch_pc;
        resp_pc  <= branch_pc;
        // Every request still in flight after this edge is stale: the old
        // discard backlog plus all live requests, minus a response consumed
        // this cycle (which is itself dropped).
        discard  <= outstanding_dec;
      end else begin
        if (handshake) begin
          fetch_pc <= fetch_pc + 32'd4;
        end
        if (ICACHE_VALID && (discard != '0)) begin
          discard <= discard - ONE;
        end
        if (push) begin
          resp_pc <= resp_pc + 32'd4;
        end
      end
    end
  end

  // FIFO storage; no reset needed, pointers and count qualify the contents
  always_ff @(posedge CLK) begin
    if (push) begin
      fifo_pc[wr_ptr]   <= resp_pc;
      fifo_data[wr_ptr] <= ICACHE_INSTRUCTION;
    end
  end

  // FIFO pointers and occupancy
  always_ff @(posedge CLK) begin
    if (RST || BRANCH_TAKEN) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + ONE;
        2'b01:   count <= count - ONE;
        default: count <= count;
      endcase
    end
  end

  // Output register to the decoding stage. The head is read before any
  // same-edge push lands, so a response never bypasses straight to decode.
  always_ff @(posedge CLK) begin
    if (RST || BRANCH_TAKEN || CLEAR_FETCH_STAGE) begin
      PC_OUT            <= 32'h0;
      INSTRUCTION       <= NOP;
      INSTRUCTION_VALID <= 1'b0;
    end else if (!STALL_FETCH_STAGE) begin
      if (pop) begin
        PC_OUT            <= fifo_pc[rd_ptr];
        INSTRUCTION       <= fifo_data[rd_ptr];
        INSTRUCTION_VALID <= 1'b1;
      end else begin
        PC_OUT            <= 32'h0;
        INSTRUCTION       <= NOP;
        INSTRUCTION_VALID <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_instruction_fetch_stage.sv
// ---------------------------------------------------------------------------
// tb_instruction_fetch_stage
//
// Drives instruction_fetch_stage with a behavioural in-order cache (random
// ready and latency, data derived from the address) and compares every cycle
// against a transaction-level reference model built from queues: a list of
// in-flight fetch PCs tagged stale/live and an expected queue of buffered PCs.
// ---------------------------------------------------------------------------
module tb_instruction_fetch_stage;

  localparam int          FIFO_DEPTH = 4;
  localparam logic [31:0] NOP        = 32'h0000_0013;
  localparam logic [31:0] PC_RESET   = 32'h0000_0000;

  // ---------------- clock / reset / DUT signals ----------------
  logic        CLK;
  logic        RST;
  logic        STALL_FETCH_STAGE;
  logic        CLEAR_FETCH_STAGE;
  logic        BRANCH_TAKEN;
  logic [31:0] BRANCH_TARGET;
  logic        ICACHE_REQUEST;
  logic [31:0] ICACHE_ADDRESS;
  logic        ICACHE_READY;
  logic        ICACHE_VALID;
  logic [31:0] ICACHE_INSTRUCTION;
  logic [31:0] PC_OUT;
  logic [31:0] INSTRUCTION;
  logic        INSTRUCTION_VALID;

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  instruction_fetch_stage #(
    .PC_RESET  (PC_RESET),
    .NOP       (NOP),
    .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .CLK               (CLK),
    .RST               (RST),
    .STALL_FETCH_STAGE (STALL_FETCH_STAGE),
    .CLEAR_FETCH_STAGE (CLEAR_FETCH_STAGE),
    .BRANCH_TAKEN      (BRANCH_TAKEN),
    .BRANCH_TARGET     (BRANCH_TARGET),
    .ICACHE_REQUEST    (ICACHE_REQUEST),
    .ICACHE_ADDRESS    (ICACHE_ADDRESS),
    .ICACHE_READY      (ICACHE_READY),
    .ICACHE_VALID      (ICACHE_VALID),
    .ICACHE_INSTRUCTION(ICACHE_INSTRUCTION),
    .PC_OUT            (PC_OUT),
    .INSTRUCTION       (INSTRUCTION),
    .INSTRUCTION_VALID (INSTRUCTION_VALID)
  );

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] addr);
    return (addr * 32'h9E37_79B1) ^ 32'h1234_5678;
  endfunction

  // ---------------- cache model ----------------
  typedef struct {
    logic [31:0] addr;
    int          due;
  } creq_t;
  creq_t cq[$];
  int    edge_cnt = 0;
  int    lat_min  = 1;
  int    lat_max  = 1;

  // ---------------- reference model / scoreboard ----------------
  typedef struct {
    logic [31:0] pc;
    bit          stale;
  } infl_t;
  infl_t       m_inflight[$];
  logic [31:0] exp_q[$];       // PCs buffered and awaiting decode
  logic [31:0] m_fetch_pc = PC_RESET;
  logic [31:0] m_pc       = 32'h0;
  logic [31:0] m_ins      = NOP;
  logic        m_v        = 1'b0;

  // ---------------- driver: one full clock cycle ----------------
  task automatic cycle(input logic rst_i, input logic stl_i, input logic clr_i,
                       input logic br_i, input logic [31:0] tgt_i, input logic rdy_i);
    logic        cvalid;
    logic        m_req;
    logic        hs;
    logic [31:0] addr_s;
    infl_t       e;
    infl_t       tmp;
    @(negedge CLK);
    RST               = rst_i;
    STALL_FETCH_STAGE = stl_i;
    CLEAR_FETCH_STAGE = clr_i;
    BRANCH_TAKEN      = br_i;
    BRANCH_TARGET     = tgt_i;
    ICACHE_READY      = rdy_i;
    cvalid = !rst_i && (cq.size() > 0) && (cq[0].due <= edge_cnt + 1);
    ICACHE_VALID       = cvalid;
    ICACHE_INSTRUCTION = cvalid ? mem_word(cq[0].addr) : $urandom();
    #1;
    m_req = !rst_i && !br_i && ((m_inflight.size() + exp_q.size()) < FIFO_DEPTH);
    check_eq("icache_request", {31'b0, ICACHE_REQUEST}, {31'b0, m_req});
    if (m_req) check_eq("icache_address", ICACHE_ADDRESS, m_fetch_pc);
    hs     = ICACHE_REQUEST && rdy_i;
    addr_s = ICACHE_ADDRESS;

    @(posedge CLK);
    edge_cnt++;
    // cache reacts to what the DUT actually did
    if (rst_i) begin
      cq.delete();
    end else begin
      if (cvalid) void'(cq.pop_front());
      if (hs) cq.push_back('{addr_s, edge_cnt + $urandom_range(lat_max, lat_min)});
    end

    // reference model update
    if (rst_i) begin
      m_fetch_pc = PC_RESET;
      m_inflight.delete();
      exp_q.delete();
      m_pc = 32'h0; m_ins = NOP; m_v = 1'b0;
    end else begin
      if (br_i || clr_i) begin
        m_pc = 32'h0; m_ins = NOP; m_v = 1'b0;
      end else if (!stl_i) begin
        if (exp_q.size() > 0) begin
          m_pc = exp_q.pop_front(); m_ins = mem_word(m_pc); m_v = 1'b1;
        end else begin
          m_pc = 32'h0; m_ins = NOP; m_v = 1'b0;
        end
      end
      if (cvalid) begin
        check_eq("resp_has_request", {31'b0, (m_inflight.size() > 0)}, 32'd1);
        if (m_inflight.size() > 0) begin
          e = m_inflight.pop_front();
          if (!e.stale && !br_i) exp_q.push_back(e.pc);
        end
      end
      if (br_i) begin
        exp_q.delete();
        for (int i = 0; i < m_inflight.size(); i++) begin
          tmp = m_inflight[i]; tmp.stale = 1'b1; m_inflight[i] = tmp;
        end
        m_fetch_pc = {tgt_i[31:2], 2'b00};
      end else if (m_req && rdy_i) begin
        m_inflight.push_back('{m_fetch_pc, 1'b0});
        m_fetch_pc = m_fetch_pc + 32'd4;
      end
    end

    #1;
    check_eq("pc_out", PC_OUT, m_pc);
    check_eq("instruction", INSTRUCTION, m_ins);
    check_eq("instruction_valid", {31'b0, INSTRUCTION_VALID}, {31'b0, m_v});
  endtask

  task automatic run_plain(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) cycle(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bit seen;
    RST = 1'b1; STALL_FETCH_STAGE = 1'b0; CLEAR_FETCH_STAGE = 1'b0;
    BRANCH_TAKEN = 1'b0; BRANCH_TARGET = 32'h0; ICACHE_READY = 1'b1;
    ICACHE_VALID = 1'b0; ICACHE_INSTRUCTION = 32'h0;

    // 1. reset and startup latency with a 1-cycle cache
    lat_min = 1; lat_max = 1;
    do_reset(2);
    check_eq("reset_pc", PC_OUT, 32'h0);
    check_eq("reset_ins", INSTRUCTION, NOP);
    check_eq("reset_valid", {31'b0, INSTRUCTION_VALID}, 32'd0);
    run_plain(3);
    check_eq("first_pc", PC_OUT, 32'h0);
    check_eq("first_valid", {31'b0, INSTRUCTION_VALID}, 32'd1);
    run_plain(2);
    check_eq("third_pc", PC_OUT, 32'h8);

    // 2. stall for 3 cycles: output holds PC 0x8, FIFO fills
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
    check_eq("stall_hold_pc", PC_OUT, 32'h8);
    run_plain(1);
    check_eq("after_stall_pc", PC_OUT, 32'hC);
    run_plain(1);
    check_eq("after_stall_pc2", PC_OUT, 32'h10);

    // 3. clear while output holds 0x10: bubble, then 0x14
    cycle(1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
    check_eq("clear_valid", {31'b0, INSTRUCTION_VALID}, 32'd0);
    run_plain(1);
    check_eq("after_clear_pc", PC_OUT, 32'h14);

    // 4. redirect with 2 requests outstanding on a 3-cycle cache
    lat_min = 3; lat_max = 3;
    do_reset(2);
    run_plain(2);
    cycle(1'b0, 1'b0, 1'b0, 1'b1, 32'h103, 1'b1);
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      run_plain(1);
      if (INSTRUCTION_VALID && !seen) begin
        seen = 1'b1;
        check_eq("redir_first_pc", PC_OUT, 32'h100);
        check_eq("redir_first_ins", INSTRUCTION, mem_word(32'h100));
      end
    end
    check_eq("redir_output_seen", {31'b0, seen}, 32'd1);

    // 5. redirect together with stall, clear and a cache response
    lat_min = 1; lat_max = 1;
    run_plain(4);
    cycle(1'b0, 1'b1, 1'b1, 1'b1, 32'h200, 1'b1);
    check_eq("redir_edge_valid", {31'b0, INSTRUCTION_VALID}, 32'd0);
    run_plain(6);

    // 6. reset mid-flight on a slow cache
    lat_min = 4; lat_max = 4;
    run_plain(3);
    do_reset(1);
    check_eq("midreset_valid", {31'b0, INSTRUCTION_VALID}, 32'd0);
    run_plain(8);

    // randomized phase
    lat_min = 1; lat_max = 4;
    for (int i = 0; i < 3000; i++) begin
      cycle(($urandom_range(199, 0) == 0),
            ($urandom_range(99, 0) < 25),
            ($urandom_range(99, 0) < 8),
            ($urandom_range(99, 0) < 5),
            $urandom(),
            ($urandom_range(99, 0) < 75));
    end
    run_plain(10);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
